// File: rtl/rename_pkg.sv
// Shared constants, output-lane record and ring-pointer helper for the rename stage.
package rename_pkg;

  localparam int DEF_WIDTH        = 2;
  localparam int DEF_COMMIT_WIDTH = 2;
  localparam int DEF_ARCH_REGS    = 32;
  localparam int DEF_PHYS_REGS    = 64;

  localparam int PW = $clog2(DEF_PHYS_REGS);
  localparam int AW = $clog2(DEF_ARCH_REGS);

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] ps1;
    logic [PW-1:0] ps2;
    logic [PW-1:0] pd;
    logic [PW-1:0] old_pd;
  } rename_lane_t;

  // Advance a ring index; inc is always smaller than depth.
  function automatic int ring_add(input int ptr, input int inc, input int depth);
    int sum;
    sum = ptr + inc;
    return (sum >= depth) ? sum - depth : sum;
  endfunction

endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of physical registers: WIDTH pop ports via a head window,
// COMMIT_WIDTH push ports at tail. p0 is filtered out on push.
module free_list_fifo #(
  parameter  int WIDTH        = 2,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int ARCH_REGS    = 32,
  parameter  int PHYS_REGS    = 64,
  localparam int PW           = $clog2(PHYS_REGS),
  localparam int CW           = $clog2(WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              pop_count,
  input  logic [COMMIT_WIDTH-1:0]    push_valid,
  input  logic [COMMIT_WIDTH*PW-1:0] push_pd,
  output logic [WIDTH*PW-1:0]        head_pd,
  output logic [PW:0]                count
);
  import rename_pkg::*;

  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]           mem_q [DEPTH];
  logic [IW-1:0]           head_q;
  logic [IW-1:0]           tail_q;
  logic [PW:0]             count_q;
  logic [COMMIT_WIDTH-1:0] push_en;
  logic [IW-1:0]           push_idx [COMMIT_WIDTH];
  logic [PW:0]             push_total;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_pd = '0;
    for (int k = 0; k < WIDTH; k++) begin
      head_pd[k*PW +: PW] = mem_q[IW'(ring_add(int'(head_q), k, DEPTH))];
    end
  end

  // Accepted pushes are packed into consecutive tail slots in slot order.
  always_comb begin
    int n;
    n          = 0;
    push_en    = '0;
    push_total = '0;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      push_idx[c] = IW'(ring_add(int'(tail_q), n, DEPTH));
      push_en[c]  = push_valid[c] && (push_pd[c*PW +: PW] != '0);
      if (push_en[c]) n++;
    end
    push_total = (PW+1)'(n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this storage is reset because its post-reset contents are architecturally defined.
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= PW'(ARCH_REGS + k);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= (PW+1)'(DEPTH);
    end else begin
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (push_en[c]) mem_q[push_idx[c]] <= push_pd[c*PW +: PW];
      end
      head_q  <= IW'(ring_add(int'(head_q), int'(pop_count), DEPTH));
      tail_q  <= IW'(ring_add(int'(tail_q), int'(push_total), DEPTH));
      count_q <= count_q + push_total - (PW+1)'(pop_count);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rename_stage_nw.sv
// N-lane register rename: RAT lookup with in-group bypass, free-list allocation,
// one registered output stage with ready/valid on both sides.
module rename_stage_nw #(
  parameter  int WIDTH        = rename_pkg::DEF_WIDTH,
  parameter  int COMMIT_WIDTH = rename_pkg::DEF_COMMIT_WIDTH,
  parameter  int ARCH_REGS    = rename_pkg::DEF_ARCH_REGS,
  parameter  int PHYS_REGS    = rename_pkg::DEF_PHYS_REGS,
  localparam int PW           = $clog2(PHYS_REGS),
  localparam int AW           = $clog2(ARCH_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_valid,
  input  logic [WIDTH-1:0]           in_wen,
  input  logic [WIDTH*AW-1:0]        in_rs1,
  input  logic [WIDTH*AW-1:0]        in_rs2,
  input  logic [WIDTH*AW-1:0]        in_rd,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*PW-1:0]        out_ps1,
  output logic [WIDTH*PW-1:0]        out_ps2,
  output logic [WIDTH*PW-1:0]        out_pd,
  output logic [WIDTH*PW-1:0]        out_old_pd,
  input  logic [COMMIT_WIDTH-1:0]    commit_valid,
  input  logic [COMMIT_WIDTH*PW-1:0] commit_pd,
  output logic [PW:0]                free_count
);
  import rename_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  rename_lane_t       lane_d [WIDTH];
  rename_lane_t       lane_q [WIDTH];
  logic [PW-1:0]      rat_q  [ARCH_REGS];
  logic [PW-1:0]      new_pd [WIDTH];
  logic [WIDTH*PW-1:0] head_pd;
  logic [WIDTH-1:0]   alloc;
  logic [CW-1:0]      pop_count;
  logic               accept;

  free_list_fifo #(
    .WIDTH       (WIDTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .ARCH_REGS   (ARCH_REGS),
    .PHYS_REGS   (PHYS_REGS)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop_count (pop_count),
    .push_valid(commit_valid),
    .push_pd   (commit_pd),
    .head_pd   (head_pd),
    .count     (free_count)
  );

  // Conservative: a full WIDTH worth of free registers, regardless of lane contents.
  assign in_ready = ((out_valid == '0) || out_ready) && (free_count >= (PW+1)'(WIDTH));
  assign accept   = (|in_valid) && in_ready;

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc[i]  = in_valid[i] && in_wen[i] && (in_rd[i*AW +: AW] != '0);
      new_pd[i] = '0;
      if (alloc[i]) begin
        new_pd[i] = head_pd[n*PW +: PW];
        n++;
      end
    end
    pop_count = accept ? CW'(n) : '0;
  end

  // Later lanes see the newest in-group producer; ascending scan lets the highest lane win.
  always_comb begin
    logic [AW-1:0] s1, s2, d, rdi;
    logic [PW-1:0] p1, p2, po;
    for (int j = 0; j < WIDTH; j++) begin
      s1 = in_rs1[j*AW +: AW];
      s2 = in_rs2[j*AW +: AW];
      d  = in_rd[j*AW +: AW];
      p1 = rat_q[s1];
      p2 = rat_q[s2];
      po = rat_q[d];
      for (int i = 0; i < WIDTH; i++) begin
        rdi = in_rd[i*AW +: AW];
        if (i < j && alloc[i]) begin
          if (rdi == s1) p1 = new_pd[i];
          if (rdi == s2) p2 = new_pd[i];
          if (rdi == d)  po = new_pd[i];
        end
      end
      if (s1 == '0) p1 = '0;
      if (s2 == '0) p2 = '0;
      lane_d[j] = '0;
      if (in_valid[j]) begin
        lane_d[j].valid = 1'b1;
        lane_d[j].ps1   = p1;
        lane_d[j].ps2   = p2;
        if (alloc[j]) begin
          lane_d[j].pd     = new_pd[j];
          lane_d[j].old_pd = po;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < WIDTH; j++) lane_q[j] <= '0;
      for (int a = 0; a < ARCH_REGS; a++) rat_q[a] <= PW'(a);
    end else if (accept) begin
      for (int j = 0; j < WIDTH; j++) lane_q[j] <= lane_d[j];
      // Duplicate rd: the later lane's assignment is the one that lands.
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc[i]) rat_q[in_rd[i*AW +: AW]] <= new_pd[i];
      end
    end else if (out_ready) begin
      for (int j = 0; j < WIDTH; j++) lane_q[j].valid <= 1'b0;
    end
  end

  always_comb begin
    out_valid  = '0;
    out_ps1    = '0;
    out_ps2    = '0;
    out_pd     = '0;
    out_old_pd = '0;
    for (int j = 0; j < WIDTH; j++) begin
      out_valid[j]            = lane_q[j].valid;
      out_ps1[j*PW +: PW]     = lane_q[j].ps1;
      out_ps2[j*PW +: PW]     = lane_q[j].ps2;
      out_pd[j*PW +: PW]      = lane_q[j].pd;
      out_old_pd[j*PW +: PW]  = lane_q[j].old_pd;
    end
  end

endmodule

// File: tb/tb_rename_stage_nw.sv
// Self-checking bench for rename_stage_nw: sequential-semantics reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_rename_stage_nw;
  localparam int W  = 2;
  localparam int CM = 2;
  localparam int AR = 32;
  localparam int PR = 64;
  localparam int PW = 6;
  localparam int AW = 5;
  localparam int FL = PR - AR;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    in_valid, in_wen;
  logic [W*AW-1:0] in_rs1, in_rs2, in_rd;
  logic            in_ready;
  logic [W-1:0]    out_valid;
  logic            out_ready;
  logic [W*PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic [CM-1:0]   commit_valid;
  logic [CM*PW-1:0] commit_pd;
  logic [PW:0]     free_count;

  int total;
  int bad;

  rename_stage_nw #(.WIDTH(W), .COMMIT_WIDTH(CM), .ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_wen(in_wen), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
    .commit_valid(commit_valid), .commit_pd(commit_pd), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int rat [AR];
  int fl[$];
  int pool[$];
  int e_valid [W];
  int e_ps1 [W];
  int e_ps2 [W];
  int e_pd [W];
  int e_old [W];

  task automatic model_reset();
    for (int a = 0; a < AR; a++) rat[a] = a;
    fl.delete();
    for (int k = 0; k < FL; k++) fl.push_back(AR + k);
    pool.delete();
    for (int j = 0; j < W; j++) begin
      e_valid[j] = 0; e_ps1[j] = 0; e_ps2[j] = 0; e_pd[j] = 0; e_old[j] = 0;
    end
  endtask

  function automatic bit model_ready();
    return ((e_valid[0] == 0 && e_valid[1] == 0) || out_ready) && (fl.size() >= W);
  endfunction

  // Lanes behave as if renamed one after another against a running RAT copy.
  task automatic model_step();
    int tmp [AR];
    int s1, s2, d, p;
    if ((in_valid != '0) && model_ready()) begin
      tmp = rat;
      for (int j = 0; j < W; j++) begin
        e_valid[j] = 0; e_ps1[j] = 0; e_ps2[j] = 0; e_pd[j] = 0; e_old[j] = 0;
        if (in_valid[j]) begin
          s1 = int'(in_rs1[j*AW +: AW]);
          s2 = int'(in_rs2[j*AW +: AW]);
          d  = int'(in_rd[j*AW +: AW]);
          e_valid[j] = 1;
          e_ps1[j] = tmp[s1];
          e_ps2[j] = tmp[s2];
          if (in_wen[j] && d != 0) begin
            p = fl.pop_front();
            e_pd[j]  = p;
            e_old[j] = tmp[d];
            pool.push_back(tmp[d]);
            tmp[d] = p;
          end
        end
      end
      rat = tmp;
    end else if (out_ready) begin
      for (int j = 0; j < W; j++) e_valid[j] = 0;
    end
    for (int c = 0; c < CM; c++) begin
      p = int'(commit_pd[c*PW +: PW]);
      if (commit_valid[c] && p != 0) begin
        if (fl.size() >= FL) begin
          bad++;
          $display("FAIL push_into_full pd=%0d size=%0d", p, fl.size());
        end
        fl.push_back(p);
        for (int k = 0; k < pool.size(); k++) begin
          if (pool[k] == p) begin
            pool.delete(k);
            break;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < W; j++) begin
        check($sformatf("m.valid%0d", j), 32'(out_valid[j]), 32'(e_valid[j]));
        check($sformatf("m.ps1_%0d", j), 32'(out_ps1[j*PW +: PW]), 32'(e_ps1[j]));
        check($sformatf("m.ps2_%0d", j), 32'(out_ps2[j*PW +: PW]), 32'(e_ps2[j]));
        check($sformatf("m.pd%0d", j), 32'(out_pd[j*PW +: PW]), 32'(e_pd[j]));
        check($sformatf("m.old%0d", j), 32'(out_old_pd[j*PW +: PW]), 32'(e_old[j]));
      end
      check("m.free_count", 32'(free_count), 32'(fl.size()));
      check("m.in_ready", 32'(in_ready), 32'(model_ready()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    in_valid = '0; in_wen = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    commit_valid = '0; commit_pd = '0;
  endtask

  task automatic set_lane(input int l, input bit v, input bit w, input int s1, input int s2, input int d);
    in_valid[l] = v;
    in_wen[l]   = w;
    in_rs1[l*AW +: AW] = AW'(s1);
    in_rs2[l*AW +: AW] = AW'(s2);
    in_rd[l*AW +: AW]  = AW'(d);
  endtask

  task automatic chk_lane(input string tag, input int l, input int v, input int p1, input int p2,
                          input int pd, input int po);
    check({tag, ".valid"}, 32'(out_valid[l]), 32'(v));
    check({tag, ".ps1"}, 32'(out_ps1[l*PW +: PW]), 32'(p1));
    check({tag, ".ps2"}, 32'(out_ps2[l*PW +: PW]), 32'(p2));
    check({tag, ".pd"}, 32'(out_pd[l*PW +: PW]), 32'(pd));
    check({tag, ".old_pd"}, 32'(out_old_pd[l*PW +: PW]), 32'(po));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.free_count", 32'(free_count), 32'(FL));
    check("arst.in_ready", 32'(in_ready), 1);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_reg();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, AR - 1));
  endfunction

  task automatic rand_drive();
    int taken, r, idx;
    in_valid = W'($urandom);
    in_wen   = W'($urandom);
    for (int l = 0; l < W; l++) begin
      in_rs1[l*AW +: AW] = rand_reg();
      in_rs2[l*AW +: AW] = rand_reg();
      in_rd[l*AW +: AW]  = rand_reg();
    end
    out_ready    = ($urandom_range(0, 3) != 0);
    commit_valid = '0;
    commit_pd    = '0;
    taken = -1;
    for (int c = 0; c < CM; c++) begin
      r = int'($urandom_range(0, 4));
      if (r >= 2 && pool.size() > 0) begin
        idx = int'($urandom_range(0, pool.size() - 1));
        if (idx != taken) begin
          commit_valid[c] = 1'b1;
          commit_pd[c*PW +: PW] = PW'(pool[idx]);
          taken = idx;
        end
      end else if (r == 0) begin
        commit_valid[c] = 1'b1;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    #12 rst = 1'b0;

    @(negedge clk);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_pd", 32'(out_pd), 0);
    check("reset.free_count", 32'(free_count), 32);
    check("reset.in_ready", 32'(in_ready), 1);

    // add x3,x1,x2 ; add x4,x3,x3
    #1 idle();
    set_lane(0, 1, 1, 1, 2, 3);
    set_lane(1, 1, 1, 3, 3, 4);
    @(negedge clk);
    chk_lane("dep.l0", 0, 1, 1, 2, 32, 3);
    chk_lane("dep.l1", 1, 1, 32, 32, 33, 4);
    check("dep.free_count", 32'(free_count), 30);

    // both lanes write x5
    #1 idle();
    set_lane(0, 1, 1, 3, 4, 5);
    set_lane(1, 1, 1, 5, 0, 5);
    @(negedge clk);
    chk_lane("dup.l0", 0, 1, 32, 33, 34, 5);
    chk_lane("dup.l1", 1, 1, 34, 0, 35, 34);
    check("dup.free_count", 32'(free_count), 28);

    // x0 destination, wen=0, x0 source
    #1 idle();
    set_lane(0, 1, 1, 0, 5, 0);
    set_lane(1, 1, 0, 4, 5, 7);
    @(negedge clk);
    chk_lane("x0.l0", 0, 1, 0, 35, 0, 0);
    chk_lane("x0.l1", 1, 1, 33, 35, 0, 0);
    check("x0.free_count", 32'(free_count), 28);

    // reset while a group is held at the output
    #1 idle();
    set_lane(0, 1, 1, 1, 1, 6);
    @(negedge clk);
    check("mid.out_valid", 32'(out_valid), 1);
    #1 idle();
    reset_pulse();
    set_lane(0, 1, 1, 3, 4, 3);
    @(negedge clk);
    chk_lane("post_rst.l0", 0, 1, 3, 4, 32, 3);
    chk_lane("post_rst.l1", 1, 0, 0, 0, 0, 0);

    // exhaust the free list
    #1 idle();
    reset_pulse();
    for (int g = 0; g < 16; g++) begin
      idle();
      set_lane(0, 1, 1, 1, 2, 3);
      set_lane(1, 1, 1, 3, 2, 4);
      @(negedge clk);
      if (g == 14) begin
        check("ex15.free_count", 32'(free_count), 2);
        check("ex15.in_ready", 32'(in_ready), 1);
      end
      if (g == 15) begin
        check("ex16.free_count", 32'(free_count), 0);
        check("ex16.in_ready", 32'(in_ready), 0);
      end
      #1;
    end
    idle();
    commit_valid = 2'b11;
    commit_pd = {6'd4, 6'd3};
    @(negedge clk);
    check("refill.free_count", 32'(free_count), 2);
    check("refill.in_ready", 32'(in_ready), 1);
    #1 idle();
    set_lane(0, 1, 1, 1, 2, 8);
    set_lane(1, 1, 1, 8, 2, 9);
    @(negedge clk);
    chk_lane("refill.l0", 0, 1, 1, 2, 3, 8);
    chk_lane("refill.l1", 1, 1, 3, 2, 4, 9);

    // backpressure for three cycles, with a commit during the stall
    #1 idle();
    out_ready = 1'b0;
    set_lane(0, 1, 1, 1, 1, 10);
    commit_valid = 2'b11;
    commit_pd = {6'd33, 6'd32};
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("bp.in_ready", 32'(in_ready), 0);
      check("bp.out_valid", 32'(out_valid), 3);
      check("bp.pd0", 32'(out_pd[0 +: PW]), 3);
      check("bp.pd1", 32'(out_pd[PW +: PW]), 4);
      check("bp.free_count", 32'(free_count), 2);
      #1 commit_valid = '0;
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk_lane("bp.rel_l0", 0, 1, 1, 1, 32, 10);
    chk_lane("bp.rel_l1", 1, 0, 0, 0, 0, 0);
    check("bp.rel_free", 32'(free_count), 1);
    check("bp.rel_ready", 32'(in_ready), 0);

    // randomized traffic
    #1 idle();
    out_ready = 1'b1;
    reset_pulse();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_drive();
      @(negedge clk);
      #1;
    end
    idle();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
